// File: rtl/gyro_pkg.sv
// Shared types, defaults and saturation helper for the gyro bias corrector.
package gyro_pkg;

  typedef enum logic [1:0] {
    WAIT_BOOT = 2'd0,
    CALIBRATE = 2'd1,
    RUN       = 2'd2
  } gyro_state_t;

  localparam int CAL_SHIFT_DEF = 8;
  localparam int LPF_SHIFT_DEF = 3;

  function automatic logic signed [15:0] sat16(
    input logic signed [16:0] v
  );
    if (v[16] == v[15]) return v[15:0];
    else if (v[16]) return 16'sh8000;
    else return 16'sh7fff;
  endfunction

endpackage

// File: rtl/gyro_axis_corrector.sv
// One axis: bias accumulator, subtract/saturate and optional IIR stage.
// Filter present only when GYRO_LPF_EN is defined.
module gyro_axis_corrector
  import gyro_pkg::*;
#(
  parameter int CAL_SHIFT = CAL_SHIFT_DEF
`ifdef GYRO_LPF_EN
  , parameter int LPF_SHIFT = LPF_SHIFT_DEF
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               acc_en,
  input  logic               load,
  input  logic               run_en,
  input  logic signed [15:0] sample,
  output logic signed [15:0] rate
);

  logic signed [15+CAL_SHIFT:0] acc;
  logic signed [15+CAL_SHIFT:0] sample_ext;
  logic signed [15:0]           bias;
  logic signed [16:0]           diff;
  logic signed [15:0]           sat;

  assign sample_ext = {{CAL_SHIFT{sample[15]}}, sample};
  assign diff       = {sample[15], sample} - {bias[15], bias};
  assign sat        = sat16(diff);

  always_ff @(posedge clk) begin
    if (rst || clr) acc <= '0;
    else if (acc_en) acc <= acc + sample_ext;
  end

  // Top bits of the accumulator are the floor of acc / 2^CAL_SHIFT.
  always_ff @(posedge clk) begin
    if (rst) bias <= '0;
    else if (load) bias <= acc[CAL_SHIFT +: 16];
  end

`ifdef GYRO_LPF_EN
  logic signed [15:0] s_q;
  logic signed [15:0] y;
  logic               upd_q;
  logic signed [16:0] d;
  logic signed [16:0] step;
  logic signed [16:0] ysum;

  assign d    = {s_q[15], s_q} - {y[15], y};
  assign step = d >>> LPF_SHIFT;
  assign ysum = {y[15], y} + step;

  always_ff @(posedge clk) begin
    if (rst) s_q <= '0;
    else if (run_en) s_q <= sat;
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      upd_q <= 1'b0;
      y     <= '0;
    end else begin
      upd_q <= run_en;
      if (upd_q) y <= sat16(ysum);
    end
  end

  assign rate = y;
`else
  logic signed [15:0] rate_q;

  always_ff @(posedge clk) begin
    if (rst) rate_q <= '0;
    else if (run_en) rate_q <= sat;
  end

  assign rate = rate_q;
`endif

endmodule

// File: rtl/gyro_bias_corrector.sv
// Gyro bias calibration FSM, sample edge detect and three axis correctors.
// Optional IIR smoothing of the output enabled by defining GYRO_LPF_EN.
module gyro_bias_corrector
  import gyro_pkg::*;
#(
  parameter int CAL_SHIFT = CAL_SHIFT_DEF,
  parameter int LPF_SHIFT = LPF_SHIFT_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [15:0] gyro_xout,
  input  logic signed [15:0] gyro_yout,
  input  logic signed [15:0] gyro_zout,
  input  logic               booting,
  input  logic               data_ready,
  input  logic               recal,
  output logic signed [15:0] rate_x,
  output logic signed [15:0] rate_y,
  output logic signed [15:0] rate_z,
  output logic               rate_valid,
  output logic               calibrated
);

  if (CAL_SHIFT < 1 || CAL_SHIFT > 12) begin : g_bad_cal
    $error("CAL_SHIFT out of range 1..12");
  end
  if (LPF_SHIFT < 1 || LPF_SHIFT > 8) begin : g_bad_lpf
    $error("LPF_SHIFT out of range 1..8");
  end

  gyro_state_t        state_q;
  gyro_state_t        state_d;
  logic               dr_q;
  logic               ev;
  logic               clr;
  logic               acc_en;
  logic               load;
  logic               run_en;
  logic               cnt_full;
  logic [CAL_SHIFT:0] cnt_q;

  assign ev       = data_ready & ~dr_q;
  assign cnt_full = cnt_q[CAL_SHIFT];

  always_ff @(posedge clk) begin
    if (rst) state_q <= WAIT_BOOT;
    else state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (booting) begin
      state_d = WAIT_BOOT;
    end else begin
      unique case (state_q)
        WAIT_BOOT: state_d = CALIBRATE;
        CALIBRATE: begin
          if (recal) state_d = CALIBRATE;
          else if (cnt_full) state_d = RUN;
        end
        RUN: if (recal) state_d = CALIBRATE;
        default: state_d = WAIT_BOOT;
      endcase
    end
  end

  // Once the counter is full the next cycle only loads the bias;
  // any edge seen then is dropped.
  always_comb begin
    clr        = 1'b0;
    acc_en     = 1'b0;
    load       = 1'b0;
    run_en     = 1'b0;
    calibrated = (state_q == RUN);
    if (!booting) begin
      unique case (state_q)
        WAIT_BOOT: clr = 1'b1;
        CALIBRATE: begin
          if (recal) begin
            clr = 1'b1;
          end else begin
            load   = cnt_full;
            acc_en = ev & ~cnt_full;
          end
        end
        RUN: begin
          if (recal) clr = 1'b1;
          else run_en = ev;
        end
        default: clr = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) dr_q <= 1'b0;
    else dr_q <= data_ready;
  end

  always_ff @(posedge clk) begin
    if (rst || clr) cnt_q <= '0;
    else if (acc_en) cnt_q <= cnt_q + 1'b1;
  end

`ifdef GYRO_LPF_EN
  logic v1_q;

  always_ff @(posedge clk) begin
    if (rst || clr) v1_q <= 1'b0;
    else v1_q <= run_en;
  end

  always_ff @(posedge clk) begin
    if (rst) rate_valid <= 1'b0;
    else rate_valid <= v1_q & ~clr;
  end
`else
  always_ff @(posedge clk) begin
    if (rst) rate_valid <= 1'b0;
    else rate_valid <= run_en;
  end
`endif

  logic signed [15:0] smp [3];
  logic signed [15:0] rt  [3];

  assign smp[0] = gyro_xout;
  assign smp[1] = gyro_yout;
  assign smp[2] = gyro_zout;

  for (genvar a = 0; a < 3; a++) begin : g_axis
    gyro_axis_corrector #(
      .CAL_SHIFT (CAL_SHIFT)
`ifdef GYRO_LPF_EN
      , .LPF_SHIFT (LPF_SHIFT)
`endif
    ) u_axis (
      .clk    (clk),
      .rst    (rst),
      .clr    (clr),
      .acc_en (acc_en),
      .load   (load),
      .run_en (run_en),
      .sample (smp[a]),
      .rate   (rt[a])
    );
  end

  assign rate_x = rt[0];
  assign rate_y = rt[1];
  assign rate_z = rt[2];

endmodule

// File: tb/tb_gyro_bias_corrector.sv
// Scoreboard bench for gyro_bias_corrector with a behavioural model.
// Model follows GYRO_LPF_EN when the same macro is defined for the bench.
module tb_gyro_bias_corrector;

  localparam int CS  = 2;
  localparam int LS  = 1;
  localparam int NCAL = 1 << CS;
`ifdef GYRO_LPF_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 0;
  logic rst = 1;
  logic signed [15:0] gx = 0, gy = 0, gz = 0;
  logic booting = 1, data_ready = 0, recal = 0;
  logic signed [15:0] rate_x, rate_y, rate_z;
  logic rate_valid, calibrated;

  gyro_bias_corrector #(.CAL_SHIFT(CS), .LPF_SHIFT(LS)) dut (
    .clk        (clk),
    .rst        (rst),
    .gyro_xout  (gx),
    .gyro_yout  (gy),
    .gyro_zout  (gz),
    .booting    (booting),
    .data_ready (data_ready),
    .recal      (recal),
    .rate_x     (rate_x),
    .rate_y     (rate_y),
    .rate_z     (rate_z),
    .rate_valid (rate_valid),
    .calibrated (calibrated)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int v[3];
    int t;
  } exp_t;

  exp_t sb[$];
  int n_chk = 0;
  int n_fail = 0;

  // Behavioural reference state
  bit m_run;
  int m_n;
  int m_sum[3];
  int m_bias[3];
  int m_y[3];
  int m_last[3];

  function automatic int floor_div(int a, int sh);
    int d;
    d = 1 << sh;
    if (a >= 0) return a / d;
    return -((-a + d - 1) / d);
  endfunction

  function automatic int sat(int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic model_clear();
    m_run = 0;
    m_n = 0;
    for (int a = 0; a < 3; a++) begin
      m_sum[a] = 0;
      m_y[a] = 0;
    end
  endtask

  task automatic model_sample(int s[3], bit rc);
    exp_t e;
    if (booting) return;
    if (rc) begin
      model_clear();
      return;
    end
    if (!m_run) begin
      for (int a = 0; a < 3; a++) m_sum[a] += s[a];
      m_n++;
      if (m_n == NCAL) begin
        for (int a = 0; a < 3; a++) m_bias[a] = floor_div(m_sum[a], CS);
        m_run = 1;
      end
      return;
    end
    for (int a = 0; a < 3; a++) begin
`ifdef GYRO_LPF_EN
      m_y[a] += floor_div(sat(s[a] - m_bias[a]) - m_y[a], LS);
      e.v[a] = m_y[a];
`else
      e.v[a] = sat(s[a] - m_bias[a]);
`endif
      m_last[a] = e.v[a];
    end
    e.t = cyc;
    sb.push_back(e);
  endtask

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: every rate_valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && rate_valid) begin
      exp_t e;
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_valid: rate_x=%0d with empty scoreboard",
                 rate_x);
      end else begin
        e = sb.pop_front();
        if (int'(rate_x) != e.v[0] || int'(rate_y) != e.v[1] ||
            int'(rate_z) != e.v[2] || (cyc - e.t) != LAT) begin
          n_fail++;
          $display("FAIL rate: got (%0d,%0d,%0d) lat %0d expected (%0d,%0d,%0d) lat %0d",
                   rate_x, rate_y, rate_z, cyc - e.t,
                   e.v[0], e.v[1], e.v[2], LAT);
        end
      end
    end
  end

  task automatic send(int x, int y, int z, int hold, bit rc);
    int s[3];
    s[0] = x; s[1] = y; s[2] = z;
    gx = 16'(x); gy = 16'(y); gz = 16'(z);
    data_ready = 1;
    recal = rc;
    model_sample(s, rc);
    @(negedge clk);
    recal = 0;
    repeat (hold - 1) @(negedge clk);
    data_ready = 0;
    repeat (2) @(negedge clk);
  endtask

  function automatic int rnd16();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic send_rnd(int n);
    for (int i = 0; i < n; i++)
      send(rnd16(), rnd16(), rnd16(), int'($urandom_range(1, 3)), 0);
  endtask

  task automatic do_recal();
    recal = 1;
    model_clear();
    @(negedge clk);
    recal = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic cal4(int x0, int x1, int x2, int x3);
    send(x0, rnd16(), rnd16(), 1, 0);
    send(x1, rnd16(), rnd16(), 1, 0);
    send(x2, rnd16(), rnd16(), 1, 0);
    send(x3, rnd16(), rnd16(), 1, 0);
  endtask

  initial begin
    model_clear();
    for (int a = 0; a < 3; a++) m_last[a] = 0;
    repeat (3) @(negedge clk);
    chk("reset_rate_x", rate_x, 0);
    chk("reset_valid", rate_valid, 0);
    chk("reset_calibrated", calibrated, 0);
    rst = 0;
    repeat (2) @(negedge clk);
    chk("boot_calibrated", calibrated, 0);
    booting = 0;
    model_clear();
    repeat (2) @(negedge clk);

    cal4(100, 102, 98, 101);
    chk("cal1_calibrated", calibrated, 1);
    send(150, 0, 0, 1, 0);
    chk("bias100_rate_x", rate_x, 50);
    send_rnd(12);

    // Held data_ready counts once
    send(200, 5, -5, 3, 0);
    send(-200, 7, 9, 4, 0);

    do_recal();
    chk("recal_calibrated", calibrated, 0);
`ifdef GYRO_LPF_EN
    chk("recal_rate_x", rate_x, 0);
`else
    chk("recal_rate_x_hold", rate_x, m_last[0]);
`endif
    cal4(-3, -3, -3, -2);
    chk("cal2_calibrated", calibrated, 1);
    send(0, 0, 0, 1, 0);
`ifndef GYRO_LPF_EN
    chk("floor_bias_rate_x", rate_x, 3);
`endif

    do_recal();
    cal4(-100, -100, -100, -100);
    send(32767, 32767, -32768, 1, 0);
    do_recal();
    cal4(100, 100, 100, 100);
    send(-32768, -32768, 32767, 1, 0);
`ifndef GYRO_LPF_EN
    chk("sat_neg_rate_x", rate_x, -32768);
`endif

    // booting mid-calibrate, including a sample while booting
    do_recal();
    send(10, 10, 10, 1, 0);
    send(20, 20, 20, 1, 0);
    booting = 1;
    @(negedge clk);
    send(30, 30, 30, 1, 0);
    chk("boot_mid_calibrated", calibrated, 0);
    booting = 0;
    model_clear();
    repeat (2) @(negedge clk);
    cal4(rnd16(), rnd16(), rnd16(), rnd16());
    chk("cal3_calibrated", calibrated, 1);
    send_rnd(10);

    // recal with a same-cycle sample edge
    send(1234, 1, 1, 1, 1);
    chk("recal_ev_calibrated", calibrated, 0);
    cal4(0, 0, 0, 0);
    send(0, 0, 0, 1, 0);
    send(64, 64, 64, 1, 0);
    send(64, 64, 64, 1, 0);
    send(64, 64, 64, 2, 0);
    send_rnd(10);

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
